key_encode: RTL and testbench
=============================

Name: key_encode

Overview:
- 8-line active-low to 3-bit priority encoder with synchronizer, debounce and a valid/ready output handshake.
- Inverse of the team's 3-to-8 active-low decoder: line i driven low encodes to code i. This is the same mapping the decoder drives, so decoder output feeds straight back in.
- Sits between board switch/keypad lines (or decoder loopback) and downstream logic that consumes one code per press.

Parameters:
- DEB_CYCLES, 4, consecutive stable synchronized samples required to accept a press or a release. Legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  block enable, sampled synchronously. Low forces IDLE.
- data_in  input  8  active-low request lines, asynchronous to clk. 8'b11111111 means no request.
- data_out  output  3  encoded code of the accepted line. Stable while valid=1.
- multi  output  1  more than one line was low at acceptance. Qualified by valid.
- valid  output  1  code available.
- ready  input  1  consumer accepts the code this cycle when valid=1.

Behaviour:
- Reset, asynchronous: state=IDLE, data_out=3'd0, multi=0, valid=0, debounce counter=0, both synchronizer stages=8'hFF.
- Synchronizer: two flops on all 8 lines. Only the second stage (s) is used below.
- Priority: the lowest index low bit of s wins. code = index of that bit. any = (s != 8'hFF). many = more than one bit of s low.
- FSM states: IDLE, DEB_PRESS, HOLD, DEB_REL. All transitions occur on the rising edge of clk.
  - IDLE: valid=0. If any, then cand<=code, cnt<=0, go to DEB_PRESS.
  - DEB_PRESS: if !any or code!=cand, go to IDLE (no output). Else if cnt==DEB_CYCLES-1, then data_out<=cand, multi<=many, valid<=1, go to HOLD. Else cnt<=cnt+1.
  - HOLD: valid=1. data_out and multi are frozen. Input changes are ignored. On valid&&ready: valid<=0, cnt<=0, go to DEB_REL.
  - DEB_REL: requires !any for DEB_CYCLES consecutive cycles, then go to IDLE. Any low line resets cnt to 0 and stays in DEB_REL. There is no new code until full release.
- Latency: data_in stable from just before edge 1 gives valid high after edge DEB_CYCLES+3. With DEB_CYCLES=4, that is edge 7.
- Handshake:
  - valid stays high until accepted. ready is ignored outside HOLD.
  - valid is never deasserted without ready, except on enable low or rst.
  - Exactly one valid&&ready transfer per debounced press.
- enable=0: state is forced to IDLE on the next edge and valid<=0, even mid-HOLD, so the pending code is dropped. data_out and multi hold their last value. The synchronizer keeps running.
- Re-enable with a line still held low: this is treated as a new press and goes through the full debounce.
- Simultaneous events: enable low has priority over ready and over press detection. rst dominates everything, at any time including mid-debounce.
- Glitch of fewer than DEB_CYCLES samples: no valid. Same-code bounce restarts via IDLE.
- Counter is 8 bits, unsigned, no wrap: it saturates at the compare point.

Decomposition:
- Shared package key_pkg holds:
  - state enum typedef (IDLE, DEB_PRESS, HOLD, DEB_REL);
  - localparam LINES=8, CODE_W=3, IDLE_LINES=8'hFF.
- One natural sub-module: prio_enc8. It is combinational: s[7:0] in; code[2:0], any, many out.
- Synchronizer and FSM live in key_encode.

Test Plan:
- Single press:
  - Stimulus: DEB_CYCLES=4, data_in=8'b11110111 held, ready=1.
  - Response: valid=1 after edge 7 with data_out=3, multi=0. valid=0 after the next edge. No second valid while held.
  - Release to 8'hFF for 4+ cycles, then press 8'b01111111: data_out=7.
- Multiple lines:
  - Stimulus: data_in=8'b11011011.
  - Response: data_out=2, multi=1.
- Back-pressure:
  - Stimulus: press 8'b11111110 with ready=0 for 20 cycles, changing data_in meanwhile; then ready=1.
  - Response: valid held 1, data_out=0 stable throughout. Single transfer on the ready edge.
- Bounce:
  - Stimulus: data_in low for 3 cycles, then high for 1 cycle, repeated 5 times.
  - Response: valid never asserts.
  - Stimulus: then held low for 10 cycles.
  - Response: exactly one valid.
- Enable and reset:
  - Stimulus: deassert enable during HOLD.
  - Response: valid=0 next edge, data_out unchanged. Re-enable with the line held: valid after DEB_CYCLES+1 edges.
  - Stimulus: assert rst mid-DEB_PRESS.
  - Response: all outputs go to reset values immediately, without waiting for a clock edge.
- Decoder loopback:
  - Stimulus: for each c in 0..7, feed the decoder output for c (enable=1), with release between.
  - Response: data_out=c, multi=0 for all 8 codes.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and constants for the key encoder.
// FSM state encoding and line/code widths.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DEB_PRESS,
    HOLD,
    DEB_REL
  } state_t;

  localparam int LINES  = 8;
  localparam int CODE_W = 3;

  localparam logic [LINES-1:0] IDLE_LINES = 8'hFF;

endpackage

// File: rtl/key_encode_prio_enc8.sv
// Active-low 8-line priority encoder.
// Lowest-index low line wins; also flags any/many lines low.
module prio_enc8
  import key_pkg::*;
(
  input  logic [LINES-1:0]  s,
  output logic [CODE_W-1:0] code,
  output logic              any,
  output logic              many
);

  logic [LINES-1:0] low;

  assign low  = ~s;
  assign any  = |low;
  // clearing the lowest set bit leaves something only if 2+ were set
  assign many = |(low & (low - 1'b1));

  always_comb begin
    code = '0;
    for (int i = LINES - 1; i >= 0; i--) begin
      if (low[i]) begin
        code = CODE_W'(i);
      end
    end
  end

endmodule

// File: rtl/key_encode.sv
// Synchronized, debounced 8-line key encoder.
// One code per press via valid/ready; full release needed between presses.
module key_encode
  import key_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [LINES-1:0]  data_in,
  output logic [CODE_W-1:0] data_out,
  output logic              multi,
  output logic              valid,
  input  logic              ready
);

  localparam logic [7:0] LAST = 8'(DEB_CYCLES - 1);

  logic [LINES-1:0]  sync_q;
  logic [LINES-1:0]  s_q;
  state_t            state_q;
  state_t            state_d;
  logic [7:0]        cnt_q;
  logic [7:0]        cnt_d;
  logic [CODE_W-1:0] cand_q;
  logic [CODE_W-1:0] cand_d;
  logic [CODE_W-1:0] out_d;
  logic              multi_d;
  logic              valid_d;

  logic [CODE_W-1:0] code;
  logic              any;
  logic              many;

  prio_enc8 u_enc (
    .s    (s_q),
    .code (code),
    .any  (any),
    .many (many)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= IDLE_LINES;
      s_q    <= IDLE_LINES;
    end else begin
      sync_q <= data_in;
      s_q    <= sync_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cand_q   <= '0;
      data_out <= '0;
      multi    <= 1'b0;
      valid    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      data_out <= out_d;
      multi    <= multi_d;
      valid    <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    out_d   = data_out;
    multi_d = multi;
    valid_d = valid;
    if (!enable) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          valid_d = 1'b0;
          if (any) begin
            cand_d  = code;
            cnt_d   = '0;
            state_d = DEB_PRESS;
          end
        end
        DEB_PRESS: begin
          if (!any || code != cand_q) begin
            state_d = IDLE;
          end else if (cnt_q == LAST) begin
            out_d   = cand_q;
            multi_d = many;
            valid_d = 1'b1;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        HOLD: begin
          if (ready) begin
            valid_d = 1'b0;
            cnt_d   = '0;
            state_d = DEB_REL;
          end
        end
        DEB_REL: begin
          // any low line restarts the release window
          if (any) begin
            cnt_d = '0;
          end else if (cnt_q == LAST) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_encode.sv
// Directed bench for key_encode with DEB_CYCLES=4.
// Expected codes and latencies are hand-computed.
module tb_key_encode;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [7:0] data_in;
  logic [2:0] data_out;
  logic       multi;
  logic       valid;
  logic       ready;

  int n_cmp;
  int n_err;

  key_encode #(.DEB_CYCLES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .data_in  (data_in),
    .data_out (data_out),
    .multi    (multi),
    .valid    (valid),
    .ready    (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (!valid && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic release_lines();
    ready   = 1'b0;
    data_in = 8'hFF;
    tick(8);
  endtask

  task automatic press_expect(input string tag, input logic [7:0] lines,
                              input int code, input int mul);
    int n;
    ready   = 1'b0;
    data_in = lines;
    wait_valid(20, n);
    check({tag, "_lat"}, n, 7);
    check({tag, "_code"}, data_out, code);
    check({tag, "_multi"}, multi, mul);
    ready = 1'b1;
    tick();
    check({tag, "_xfer"}, valid, 0);
    release_lines();
  endtask

  initial begin
    int n;
    int cnt;
    logic [7:0] pat;
    n_cmp   = 0;
    n_err   = 0;
    rst     = 1'b1;
    enable  = 1'b1;
    data_in = 8'hFF;
    ready   = 1'b0;
    tick(2);
    check("rst_valid", valid, 0);
    check("rst_code", data_out, 0);
    check("rst_multi", multi, 0);
    rst = 1'b0;
    tick(2);

    // single press with ready held high
    data_in = 8'b11110111;
    ready   = 1'b1;
    tick(6);
    check("sp_early", valid, 0);
    tick();
    check("sp_valid", valid, 1);
    check("sp_code", data_out, 3);
    check("sp_multi", multi, 0);
    tick();
    check("sp_xfer", valid, 0);
    cnt = 0;
    repeat (10) begin
      tick();
      if (valid) cnt++;
    end
    check("sp_held", cnt, 0);
    release_lines();
    press_expect("sp7", 8'b01111111, 7, 0);

    press_expect("mul", 8'b11011011, 2, 1);

    // async reset mid-DEB_PRESS, outputs hold 2/1 from above
    data_in = 8'b11110111;
    tick(4);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", valid, 0);
    check("arst_code", data_out, 0);
    check("arst_multi", multi, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_valid(20, n);
    check("arst_relat", n, 7);
    check("arst_recode", data_out, 3);
    ready = 1'b1;
    tick();
    release_lines();

    // back-pressure: inputs wiggle while holding
    ready   = 1'b0;
    data_in = 8'b11111110;
    wait_valid(20, n);
    check("bp_lat", n, 7);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      data_in = 8'(i * 37 + 5);
      tick();
      if (!valid || data_out != 3'd0) cnt++;
    end
    check("bp_hold", cnt, 0);
    ready = 1'b1;
    tick();
    check("bp_xfer", valid, 0);
    data_in = 8'hFF;
    tick(3);
    check("bp_single", valid, 0);
    release_lines();

    // bounce: 3 low / 1 high never debounces
    ready = 1'b1;
    cnt   = 0;
    repeat (5) begin
      data_in = 8'b11101111;
      repeat (3) begin
        tick();
        if (valid) cnt++;
      end
      data_in = 8'hFF;
      tick();
      if (valid) cnt++;
    end
    check("bnc_none", cnt, 0);
    data_in = 8'b11101111;
    repeat (10) begin
      tick();
      if (valid) cnt++;
    end
    check("bnc_one", cnt, 1);
    check("bnc_code", data_out, 4);
    release_lines();

    // enable drop in HOLD, then re-enable with line held
    data_in = 8'b11111101;
    wait_valid(20, n);
    check("en_code", data_out, 1);
    enable = 1'b0;
    tick();
    check("en_drop", valid, 0);
    check("en_keep", data_out, 1);
    tick(3);
    check("en_idle", valid, 0);
    enable = 1'b1;
    wait_valid(20, n);
    check("en_relat", n, 5);
    check("en_recode", data_out, 1);
    ready = 1'b1;
    tick();
    release_lines();

    // decoder loopback: each one-hot-low pattern maps back to its index
    for (int c = 0; c < 8; c++) begin
      pat = ~(8'b1 << c);
      press_expect($sformatf("loop%0d", c), pat, c, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
